systolic_mac_pe: RTL and testbench

- Parameterised output-stationary processing element for the systolic array.
- Adds the following to the existing PE: per-operand valid qualifiers, signed/unsigned multiply, a wide accumulator with overflow detection, and a saturating result.
- Adds a vertical result-drain chain. Every PE in a column can unload its result at once while computation on the next tile continues.
- Instances tile into an R x C grid. A flows east, B flows south, results drain south on the psum chain.

---
 rtl/systolic_mac_pe.sv | 166 ++++++++++++++++
 tb/tb_systolic_mac_pe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element.
// A flows east and B flows south with one register stage each. Products
// accumulate into a wide accumulator. A drain pulse snapshots the result
// onto a south-flowing psum chain, which then forwards UP_CNT upstream
// results so that the bottom PE delivers the whole column back-to-back.
module systolic_mac_pe #(
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int OW     = 32,
  parameter int SIGNED = 1,
  parameter int SAT    = 1,
  parameter int UP_CNT = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [DW-1:0] b_in,
  input  logic          b_vld_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  output logic [DW-1:0] b_out,
  output logic          b_vld_out,
  input  logic          drain,
  input  logic [OW-1:0] psum_in,
  input  logic          psum_vld_in,
  output logic [OW-1:0] psum_out,
  output logic          psum_vld_out,
  output logic          ovf,
  output logic          busy
);

  localparam int CW = (UP_CNT < 2) ? 1 : $clog2(UP_CNT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(UP_CNT);
  // Saturation bounds expressed at accumulator width.
  localparam logic [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [AW-1:0] SMIN = ~SMAX;
  localparam logic [AW:0]   UMAX = {{(AW+1-OW){1'b0}}, {OW{1'b1}}};

  typedef enum logic [1:0] {IDLE, EMIT, FWD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;

  logic            mac;
  logic [2*DW-1:0] ax, bx, prod;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic            carry;
  logic            wrap;
  logic [OW-1:0]   res;

  // Product, accumulate-with-wrap detection and saturated drain value.
  always_comb begin
    mac = a_vld_in & b_vld_in;
    if (SIGNED != 0) begin
      ax = (2*DW)'($signed(a_in));
      bx = (2*DW)'($signed(b_in));
    end else begin
      ax = (2*DW)'(a_in);
      bx = (2*DW)'(b_in);
    end
    // Low 2*DW bits of the extended product equal the true product.
    prod = ax * bx;
    addend = '0;
    if (mac) begin
      if (SIGNED != 0) addend = AW'($signed(prod));
      else             addend = AW'(prod);
    end
    {carry, sum} = {1'b0, acc} + {1'b0, addend};
    if (SIGNED != 0)
      wrap = (acc[AW-1] == addend[AW-1]) && (sum[AW-1] != acc[AW-1]);
    else
      wrap = carry;
    res = sum[OW-1:0];
    if (SAT != 0) begin
      if (SIGNED != 0) begin
        if ($signed(sum) > $signed(SMAX))      res = SMAX[OW-1:0];
        else if ($signed(sum) < $signed(SMIN)) res = SMIN[OW-1:0];
      end else if ({1'b0, sum} > UMAX) begin
        res = '1;
      end
    end
  end

  // Operand pipeline, accumulator and drain state machine.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_out        <= '0;
      a_vld_out    <= 1'b0;
      b_out        <= '0;
      b_vld_out    <= 1'b0;
      acc          <= '0;
      ovf          <= 1'b0;
      psum_out     <= '0;
      psum_vld_out <= 1'b0;
      cnt          <= '0;
      busy         <= 1'b0;
      state        <= IDLE;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;

      if (state == IDLE && drain) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (mac) begin
        acc <= sum;
        if (wrap) ovf <= 1'b1;
      end

      case (state)
        IDLE: begin
          psum_vld_out <= 1'b0;
          busy         <= 1'b0;
          if (drain) begin
            psum_out     <= res;
            psum_vld_out <= 1'b1;
            busy         <= 1'b1;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (UP_CNT == 0) begin
            psum_vld_out <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            // The edge leaving EMIT already captures the first upstream
            // result, so the loaded count is pre-decremented when it is
            // valid; this keeps the column output gap-free.
            psum_out     <= psum_in;
            psum_vld_out <= psum_vld_in;
            cnt          <= psum_vld_in ? CNT_INIT - CW'(1) : CNT_INIT;
            if (psum_vld_in && UP_CNT == 1) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= FWD;
            end
          end
        end
        FWD: begin
          psum_out     <= psum_in;
          psum_vld_out <= psum_vld_in;
          if (psum_vld_in) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          psum_vld_out <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: a table of per-cycle vectors drives three
// single PEs (default, non-saturating, 32-bit accumulator) in lockstep,
// and a 4-deep column exercises the drain chain and reset mid-drain.
module tb_systolic_mac_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        clr, drain, a_vld, b_vld;
  logic [15:0] a_in, b_in;
  logic [31:0] zero32;
  logic        zero1;

  // Single-PE outputs: m = default, n = SAT=0, o = AW=32.
  logic [15:0] m_aout, m_bout, n_aout, n_bout, o_aout, o_bout;
  logic        m_avo, m_bvo, n_avo, n_bvo, o_avo, o_bvo;
  logic [31:0] m_psum, n_psum, o_psum;
  logic        m_pv, n_pv, o_pv, m_ovf, n_ovf, o_ovf, m_busy, n_busy, o_busy;

  systolic_mac_pe u_main (
    .clk(clk), .clr(clr), .a_in(a_in), .a_vld_in(a_vld), .b_in(b_in), .b_vld_in(b_vld),
    .a_out(m_aout), .a_vld_out(m_avo), .b_out(m_bout), .b_vld_out(m_bvo),
    .drain(drain), .psum_in(zero32), .psum_vld_in(zero1),
    .psum_out(m_psum), .psum_vld_out(m_pv), .ovf(m_ovf), .busy(m_busy));

  systolic_mac_pe #(.SAT(0)) u_nosat (
    .clk(clk), .clr(clr), .a_in(a_in), .a_vld_in(a_vld), .b_in(b_in), .b_vld_in(b_vld),
    .a_out(n_aout), .a_vld_out(n_avo), .b_out(n_bout), .b_vld_out(n_bvo),
    .drain(drain), .psum_in(zero32), .psum_vld_in(zero1),
    .psum_out(n_psum), .psum_vld_out(n_pv), .ovf(n_ovf), .busy(n_busy));

  systolic_mac_pe #(.AW(32)) u_ovf (
    .clk(clk), .clr(clr), .a_in(a_in), .a_vld_in(a_vld), .b_in(b_in), .b_vld_in(b_vld),
    .a_out(o_aout), .a_vld_out(o_avo), .b_out(o_bout), .b_vld_out(o_bvo),
    .drain(drain), .psum_in(zero32), .psum_vld_in(zero1),
    .psum_out(o_psum), .psum_vld_out(o_pv), .ovf(o_ovf), .busy(o_busy));

  // Column of four PEs, row 0 on top.
  logic        c_clr, c_drain;
  logic [15:0] c_a [4];
  logic [15:0] c_b [4];
  logic        c_av [4];
  logic        c_bv [4];
  logic [15:0] c_aout [4];
  logic [15:0] c_bout [4];
  logic        c_avo [4];
  logic        c_bvo [4];
  logic [31:0] c_psum [4];
  logic [31:0] c_pin [4];
  logic        c_pv [4];
  logic        c_pvin [4];
  logic        c_ovf [4];
  logic        c_busy [4];

  always_comb begin
    c_pin[0]  = '0;
    c_pvin[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      c_pin[i]  = c_psum[i-1];
      c_pvin[i] = c_pv[i-1];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_col
    systolic_mac_pe #(.UP_CNT(g)) u_pe (
      .clk(clk), .clr(c_clr), .a_in(c_a[g]), .a_vld_in(c_av[g]), .b_in(c_b[g]), .b_vld_in(c_bv[g]),
      .a_out(c_aout[g]), .a_vld_out(c_avo[g]), .b_out(c_bout[g]), .b_vld_out(c_bvo[g]),
      .drain(c_drain), .psum_in(c_pin[g]), .psum_vld_in(c_pvin[g]),
      .psum_out(c_psum[g]), .psum_vld_out(c_pv[g]), .ovf(c_ovf[g]), .busy(c_busy[g]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboards: expected drain results, popped when a valid psum appears.
  logic [31:0] q_m[$], q_n[$], q_o[$], q_c[$];

  always @(negedge clk) begin
    if (m_pv) begin
      if (q_m.size() == 0) begin checks++; errors++; $display("FAIL main_psum_unexpected: got %h expected none", m_psum); end
      else chk("main_psum", m_psum, q_m.pop_front());
    end
    if (n_pv) begin
      if (q_n.size() == 0) begin checks++; errors++; $display("FAIL nosat_psum_unexpected: got %h expected none", n_psum); end
      else chk("nosat_psum", n_psum, q_n.pop_front());
    end
    if (o_pv) begin
      if (q_o.size() == 0) begin checks++; errors++; $display("FAIL aw32_psum_unexpected: got %h expected none", o_psum); end
      else chk("aw32_psum", o_psum, q_o.pop_front());
    end
    if (c_pv[3]) begin
      if (q_c.size() == 0) begin checks++; errors++; $display("FAIL col_psum_unexpected: got %h expected none", c_psum[3]); end
      else chk("col_psum", c_psum[3], q_c.pop_front());
    end
  end

  typedef struct {
    logic [15:0] a, b;
    logic        av, bv, dr;
    logic [31:0] em, en, eo;   // drain results: default, SAT=0, AW=32
    logic        busy, ovf;    // busy of default PE, ovf of AW=32 PE
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic av,
                              input logic bv, input logic dr, input logic [31:0] em,
                              input logic [31:0] en, input logic [31:0] eo,
                              input logic busy, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.av = av; v.bv = bv; v.dr = dr;
    v.em = em; v.en = en; v.eo = eo; v.busy = busy; v.ovf = ovf;
    return v;
  endfunction

  vec_t vec [16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    zero32 = '0; zero1 = 1'b0;
    clr = 1'b1; drain = 1'b1; a_in = 16'd5; b_in = 16'd7; a_vld = 1'b1; b_vld = 1'b1;
    c_clr = 1'b1; c_drain = 1'b0;
    for (int i = 0; i < 4; i++) begin c_a[i] = '0; c_b[i] = '0; c_av[i] = 1'b0; c_bv[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("rst_psum_vld", 32'(m_pv), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_ovf", 32'(m_ovf), 32'd0);
    chk("rst_a_out", 32'(m_aout), 32'd0);
    chk("rst_psum", m_psum, 32'd0);
    chk("rst_col_vld", 32'(c_pv[3]), 32'd0);
    clr = 1'b0; c_clr = 1'b0; drain = 1'b0; a_vld = 1'b0; b_vld = 1'b0;

    //              a         b         av  bv  dr  main          nosat         aw32          busy ovf
    vec[0]  = mk(16'd3,    16'd4,    1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[1]  = mk(16'hFFFE, 16'd5,    1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[2]  = mk(16'd7,    16'hFFFF, 1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[3]  = mk(16'd0,    16'd0,    0, 0, 1, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 1, 0);
    vec[4]  = mk(16'd9,    16'd9,    1, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[5]  = mk(16'd2,    16'd2,    1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[6]  = mk(16'd0,    16'd0,    0, 0, 1, 32'd4,        32'd4,        32'd4,        1, 0);
    vec[7]  = mk(16'd10,   16'd1,    1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[8]  = mk(16'd5,    16'd5,    1, 1, 1, 32'd35,       32'd35,       32'd35,       1, 0);
    vec[9]  = mk(16'd3,    16'd3,    1, 1, 1, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[10] = mk(16'd0,    16'd0,    0, 0, 1, 32'd9,        32'd9,        32'd9,        1, 0);
    vec[11] = mk(16'h7FFF, 16'h7FFF, 1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[12] = mk(16'h7FFF, 16'h7FFF, 1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 0);
    vec[13] = mk(16'h7FFF, 16'h7FFF, 1, 1, 0, 32'd0,        32'd0,        32'd0,        0, 1);
    vec[14] = mk(16'd0,    16'd0,    0, 0, 1, 32'h7FFFFFFF, 32'hBFFD0003, 32'hBFFD0003, 1, 0);
    vec[15] = mk(16'd0,    16'd0,    0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0);

    for (int i = 0; i < 16; i++) begin
      a_in = vec[i].a; b_in = vec[i].b; a_vld = vec[i].av; b_vld = vec[i].bv; drain = vec[i].dr;
      // Row 9 pulses drain while EMIT is active, so nothing is expected.
      if (vec[i].dr && i != 9) begin
        q_m.push_back(vec[i].em); q_n.push_back(vec[i].en); q_o.push_back(vec[i].eo);
      end
      @(negedge clk);
      chk($sformatf("a_out[%0d]", i), 32'(m_aout), 32'(vec[i].a));
      chk($sformatf("b_out[%0d]", i), 32'(m_bout), 32'(vec[i].b));
      chk($sformatf("a_vld_out[%0d]", i), 32'(m_avo), 32'(vec[i].av));
      chk($sformatf("b_vld_out[%0d]", i), 32'(m_bvo), 32'(vec[i].bv));
      chk($sformatf("busy[%0d]", i), 32'(m_busy), 32'(vec[i].busy));
      chk($sformatf("main_ovf[%0d]", i), 32'(m_ovf), 32'd0);
      chk($sformatf("aw32_ovf[%0d]", i), 32'(o_ovf), 32'(vec[i].ovf));
    end
    drain = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    repeat (2) @(negedge clk);

    // Column: load 10,20,30,40 top to bottom, drain all, re-pulse at t+2.
    for (int i = 0; i < 4; i++) begin c_a[i] = 16'(10 * (i + 1)); c_b[i] = 16'd1; c_av[i] = 1'b1; c_bv[i] = 1'b1; end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin c_av[i] = 1'b0; c_bv[i] = 1'b0; end
    c_drain = 1'b1;
    q_c.push_back(32'd40); q_c.push_back(32'd30); q_c.push_back(32'd20); q_c.push_back(32'd10);
    @(negedge clk); c_drain = 1'b0; chk("col_vld_t1", 32'(c_pv[3]), 32'd1);
    @(negedge clk); c_drain = 1'b1; chk("col_vld_t2", 32'(c_pv[3]), 32'd1);
    @(negedge clk); c_drain = 1'b0; chk("col_vld_t3", 32'(c_pv[3]), 32'd1);
    @(negedge clk); chk("col_vld_t4", 32'(c_pv[3]), 32'd1);
    @(negedge clk); chk("col_vld_t5", 32'(c_pv[3]), 32'd0);
    chk("col_busy_t5", 32'(c_busy[3]), 32'd0);
    @(negedge clk); chk("col_vld_t6", 32'(c_pv[3]), 32'd0);
    repeat (2) @(negedge clk);

    // Column: reset while the bottom PE is forwarding.
    for (int i = 0; i < 4; i++) begin c_av[i] = 1'b1; c_bv[i] = 1'b1; end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin c_av[i] = 1'b0; c_bv[i] = 1'b0; end
    c_drain = 1'b1;
    q_c.push_back(32'd40); q_c.push_back(32'd30);
    @(negedge clk); c_drain = 1'b0;
    @(negedge clk); c_clr = 1'b1; chk("fwd_busy_before_clr", 32'(c_busy[3]), 32'd1);
    @(negedge clk); c_clr = 1'b0;
    chk("clr_vld", 32'(c_pv[3]), 32'd0);
    chk("clr_busy", 32'(c_busy[3]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("clr_quiet[%0d]", k), 32'(c_pv[3]), 32'd0);
    end

    chk("main_q_empty", 32'(q_m.size()), 32'd0);
    chk("nosat_q_empty", 32'(q_n.size()), 32'd0);
    chk("aw32_q_empty", 32'(q_o.size()), 32'd0);
    chk("col_q_empty", 32'(q_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
